// File: rtl/yontem1.sv
// 64-bit unsigned adder built as a three-level carry-lookahead tree.
// The sum is combinational; a registered copy of the sum and carry-out is also provided.

module yontem1_lcu4 (
    input  logic [3:0] g_i,
    input  logic [3:0] p_i,
    input  logic       c_i,
    output logic [3:0] c_o,
    output logic       g_grp_o,
    output logic       p_grp_o
);
    // c_o[k] is the carry into position k; every carry is a flat sum of products.
    assign c_o[0] = c_i;
    assign c_o[1] = g_i[0] | (p_i[0] & c_i);
    assign c_o[2] = g_i[1] | (p_i[1] & g_i[0]) | (p_i[1] & p_i[0] & c_i);
    assign c_o[3] = g_i[2] | (p_i[2] & g_i[1]) | (p_i[2] & p_i[1] & g_i[0])
                  | (p_i[2] & p_i[1] & p_i[0] & c_i);

    assign g_grp_o = g_i[3] | (p_i[3] & g_i[2]) | (p_i[3] & p_i[2] & g_i[1])
                   | (p_i[3] & p_i[2] & p_i[1] & g_i[0]);
    assign p_grp_o = &p_i;
endmodule

module yontem1_group4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] sum_o,
    output logic       g_grp_o,
    output logic       p_grp_o
);
    logic [3:0] g_w;
    logic [3:0] p_w;
    logic [3:0] c_w;

    assign g_w = a_i & b_i;
    assign p_w = a_i ^ b_i;

    yontem1_lcu4 u_lcu (
        .g_i     (g_w),
        .p_i     (p_w),
        .c_i     (c_i),
        .c_o     (c_w),
        .g_grp_o (g_grp_o),
        .p_grp_o (p_grp_o)
    );

    assign sum_o = p_w ^ c_w;
endmodule

module yontem1 #(
    parameter int WIDTH = 64,
    parameter int GROUP = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] num1_i,
    input  logic [WIDTH-1:0] num2_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic [WIDTH-1:0] sum_q_o,
    output logic             carry_q_o
);
    localparam int NGRP = WIDTH / GROUP;
    localparam int NBLK = WIDTH / 16;

    logic [NGRP-1:0] grp_g;
    logic [NGRP-1:0] grp_p;
    logic [NGRP-1:0] grp_c;
    logic [NBLK-1:0] blk_g;
    logic [NBLK-1:0] blk_p;
    logic [NBLK:0]   blk_c;
    logic [WIDTH-1:0] sum_w;

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             carry_d, carry_q;

    // Carry into block 'upto' expanded as a full sum of products over all lower blocks.
    function automatic logic lookahead_carry(
        input logic [NBLK-1:0] g,
        input logic [NBLK-1:0] p,
        input logic            cin,
        input int              upto
    );
        logic c;
        logic term;
        c = 1'b0;
        for (int k = 0; k < upto; k++) begin
            term = g[k];
            for (int m = k + 1; m < upto; m++) begin
                term = term & p[m];
            end
            c = c | term;
        end
        term = cin;
        for (int m = 0; m < upto; m++) begin
            term = term & p[m];
        end
        return c | term;
    endfunction

    genvar gi, bi, ci;

    generate
        for (gi = 0; gi < NGRP; gi++) begin : g_group
            yontem1_group4 u_group (
                .a_i     (num1_i[gi*GROUP +: GROUP]),
                .b_i     (num2_i[gi*GROUP +: GROUP]),
                .c_i     (grp_c[gi]),
                .sum_o   (sum_w[gi*GROUP +: GROUP]),
                .g_grp_o (grp_g[gi]),
                .p_grp_o (grp_p[gi])
            );
        end

        for (bi = 0; bi < NBLK; bi++) begin : g_block
            yontem1_lcu4 u_blk_lcu (
                .g_i     (grp_g[bi*4 +: 4]),
                .p_i     (grp_p[bi*4 +: 4]),
                .c_i     (blk_c[bi]),
                .c_o     (grp_c[bi*4 +: 4]),
                .g_grp_o (blk_g[bi]),
                .p_grp_o (blk_p[bi])
            );
        end

        assign blk_c[0] = 1'b0;
        for (ci = 1; ci <= NBLK; ci++) begin : g_top_carry
            assign blk_c[ci] = lookahead_carry(blk_g, blk_p, 1'b0, ci);
        end
    endgenerate

    assign sum_o   = sum_w;
    assign carry_o = blk_c[NBLK];

    assign sum_d   = sum_w;
    assign carry_d = blk_c[NBLK];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_q_o   = sum_q;
    assign carry_q_o = carry_q;
endmodule

// File: tb/tb_yontem1.sv
// Bench for yontem1: combinational sum checks against a 65-bit arithmetic model
// and a queue-based scoreboard for the one-cycle registered copy.

module tb_yontem1;
  localparam int W = 64;

  logic         clk;
  logic         rst;
  logic [W-1:0] num1;
  logic [W-1:0] num2;
  logic [W-1:0] sum;
  logic         carry;
  logic [W-1:0] sum_q;
  logic         carry_q;

  int errors = 0;
  int checks = 0;

  logic [W:0] exp_q[$];

  yontem1 #(.WIDTH(W), .GROUP(4)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .num1_i    (num1),
    .num2_i    (num2),
    .sum_o     (sum),
    .carry_o   (carry),
    .sum_q_o   (sum_q),
    .carry_q_o (carry_q)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst  = 1'b1;
    num1 = '0;
    num2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({carry_q, sum_q} !== {1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_q got carry=%b sum=%h want carry=0 sum=0", carry_q, sum_q);
    end
    num1 = rand64();
    num2 = rand64();
    @(negedge clk);
    checks++;
    if ({carry_q, sum_q} !== {1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reset_hold got carry=%b sum=%h want carry=0 sum=0", carry_q, sum_q);
    end
  endtask

  task automatic test_sweep();
    logic [W-1:0] av[4];
    logic [W-1:0] bv[4];
    logic [W:0]   exp;
    av[0] = 1; av[1] = 59; av[2] = 3481; av[3] = 205379;
    bv[0] = 1; bv[1] = 73; bv[2] = 5329; bv[3] = 389017;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        num1 = av[i];
        num2 = bv[j];
        #10;
        exp = model_add(av[i], bv[j]);
        checks++;
        if ({carry, sum} !== exp) begin
          errors++;
          $display("FAIL sweep %0d+%0d got %0d want %0d", av[i], bv[j], {carry, sum}, exp);
        end
      end
    end
    num1 = 205379;
    num2 = 389017;
    #10;
    checks++;
    if (sum !== 64'd594396) begin
      errors++;
      $display("FAIL sweep_example got %0d want 594396", sum);
    end
  endtask

  task automatic test_edges();
    logic [W-1:0] ea[6];
    logic [W-1:0] eb[6];
    logic [W:0]   ex[6];
    ea[0] = 64'h0;                   eb[0] = 64'h0; ex[0] = 65'h0;
    ea[1] = 64'h1234;                eb[1] = 64'h0; ex[1] = 65'h1234;
    ea[2] = 64'hFFFF_FFFF_FFFF_FFFF; eb[2] = 64'h1; ex[2] = 65'h1_0000_0000_0000_0000;
    ea[3] = 64'h0000_0000_FFFF_FFFF; eb[3] = 64'h1; ex[3] = 65'h0_0000_0001_0000_0000;
    ea[4] = 64'h000F;                eb[4] = 64'h1; ex[4] = 65'h10;
    ea[5] = 64'hFFFF;                eb[5] = 64'h1; ex[5] = 65'h1_0000;
    for (int i = 0; i < 6; i++) begin
      num1 = ea[i];
      num2 = eb[i];
      #1;
      checks++;
      if ({carry, sum} !== ex[i]) begin
        errors++;
        $display("FAIL edge%0d %h+%h got carry=%b sum=%h want carry=%b sum=%h",
                 i, ea[i], eb[i], carry, sum, ex[i][W], ex[i][W-1:0]);
      end
    end
  endtask

  task automatic test_registered();
    logic [W:0] exp;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({carry_q, sum_q} !== {1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reg_reset got %h want 0", {carry_q, sum_q});
    end
    rst  = 1'b0;
    num1 = 59;
    num2 = 73;
    @(negedge clk);
    checks++;
    if ({carry_q, sum_q} !== {1'b0, 64'd132}) begin
      errors++;
      $display("FAIL reg_59_73 got carry=%b sum=%0d want carry=0 sum=132", carry_q, sum_q);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({carry_q, sum_q} !== {1'b0, {W{1'b0}}}) begin
      errors++;
      $display("FAIL reg_midreset got %h want 0", {carry_q, sum_q});
    end
    checks++;
    if (sum !== 64'd132) begin
      errors++;
      $display("FAIL comb_during_reset got %0d want 132", sum);
    end
    // Registered stream of random pairs scored through the expected queue.
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 200; i++) begin
      num1 = rand64();
      num2 = rand64();
      if (i % 8 == 0) num2 = ~num1 + 64'd1;
      exp_q.push_back(model_add(num1, num2));
      @(negedge clk);
      exp = exp_q.pop_front();
      checks++;
      if ({carry_q, sum_q} !== exp) begin
        errors++;
        $display("FAIL reg_stream%0d got carry=%b sum=%h want carry=%b sum=%h",
                 i, carry_q, sum_q, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
    int           rerr;
    rerr = 0;
    for (int i = 0; i < 10000; i++) begin
      a = rand64();
      b = rand64();
      case ($urandom_range(0, 7))
        0: b = ~a;
        1: b = ~a + 64'd1;
        2: a = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      num1 = a;
      num2 = b;
      #1;
      exp = model_add(a, b);
      checks++;
      if ({carry, sum} !== exp) begin
        errors++;
        rerr++;
        if (rerr <= 10)
          $display("FAIL random %h+%h got carry=%b sum=%h want carry=%b sum=%h",
                   a, b, carry, sum, exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_edges();
    test_registered();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/yontem1.md
Name: yontem1

Overview:
- 64-bit two-operand unsigned adder built as a hierarchical carry-lookahead adder (CLA).
- Provides a combinational sum path (sum_o) that carries no pipeline latency.
- Also provides a one-cycle registered copy of the sum and carry-out, for use by synchronous consumers in the arithmetic datapath.
- Synchronous active-high reset clears only the registered outputs.

Parameters:
- WIDTH, 64, operand/sum width in bits; must be a multiple of 16.
- GROUP, 4, bits per lookahead group; fixed at 4.

Ports:
- clk_i  input  1  system clock; all registers update on the rising edge.
- rst_i  input  1  synchronous reset, active-high.
- num1_i  input  WIDTH  first unsigned operand.
- num2_i  input  WIDTH  second unsigned operand.
- sum_o  output  WIDTH  combinational sum (num1_i + num2_i) mod 2^WIDTH.
- carry_o  output  1  combinational carry-out of the MSB.
- sum_q_o  output  WIDTH  registered sum_o.
- carry_q_o  output  1  registered carry_o.

Behaviour:
- Carry-in is constant 0.
- Bit level: generate g[i] = a[i] & b[i]; propagate p[i] = a[i] ^ b[i].
- 4-bit group cells:
  - internal carries use full lookahead, e.g. c1 = g0 | p0&c0, c2 = g1 | p1&g0 | p1&p0&c0, and so on;
  - each group outputs group generate G and group propagate P.
- Second level: 4-group lookahead units form 16-bit blocks.
- Third level: lookahead across the four 16-bit blocks produces all block carries. No ripple chain is allowed between groups.
- sum[i] = p[i] ^ c[i].
- carry_o = carry into bit WIDTH.
- sum_o and carry_o are purely combinational:
  - no dependence on clk_i or rst_i;
  - valid within one propagation delay of an input change, with no clock edge required;
  - must settle in well under 10 ns in behavioural simulation (zero-delay RTL).
- Overflow: the result wraps modulo 2^WIDTH and the lost bit appears on carry_o. Example: all-ones + 1 -> sum_o = 0, carry_o = 1.
- Registered path, on each rising clk_i edge:
  - rst_i = 1: sum_q_o <= 0, carry_q_o <= 0;
  - otherwise: sum_q_o <= sum_o, carry_q_o <= carry_o.
- Latency: 0 cycles for sum_o/carry_o; 1 cycle for sum_q_o/carry_q_o.
- Reset value of sum_q_o and carry_q_o is 0. They hold 0 while rst_i is high, even if operands change.
- Reset mid-operation: the registered outputs clear on the next edge. sum_o continues to track the inputs unaffected.
- Before the first clock edge the registered outputs are unspecified (X). sum_o is valid from time 0 once inputs are known.
- No handshake, no enables, no state machine.

Test Plan:
- Operand sweep: num1_i over {1, 59, 3481, 205379} × num2_i over {1, 73, 5329, 389017}, 10 ns per vector, no clock -> sum_o == num1_i + num2_i for all 16 vectors (e.g. 205379 + 389017 -> 594396); error count 0.
- Zero and identity: 0 + 0 -> sum_o = 0, carry_o = 0; 0x1234 + 0 -> 0x1234.
- Long carry chain: 0xFFFF_FFFF_FFFF_FFFF + 1 -> sum_o = 0, carry_o = 1; 0x0000_0000_FFFF_FFFF + 1 -> 0x0000_0001_0000_0000, carry_o = 0.
- Group boundary: 0x000F + 0x0001 -> 0x0010; 0xFFFF + 0x0001 -> 0x1_0000 (crosses the 16-bit block boundary).
- Registered path: rst_i = 1 for 2 cycles -> sum_q_o = 0; release, apply 59 + 73 -> sum_q_o = 132 one edge later; assert rst_i mid-stream -> sum_q_o = 0 next edge while sum_o still = 132.
- Random: 10k random 64-bit pairs -> sum_o == (a + b)[63:0] and carry_o == (a + b)[64].
